// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: the sequencer's control bundle.
// Run and DIN go into the sequencer. The register-file, ALU and bus
// enables, together with Done and Busy, come back out.
// master = the side that issues instructions; slave = the sequencer itself.
interface alu_sequencer_if #(
    parameter int n = 16
);
    // instruction side
    logic         run;
    logic [n-1:0] din;

    // datapath control
    logic [7:0]   rin;
    logic [7:0]   rout;
    logic         ain;
    logic         gin;
    logic         gout;
    logic         dinout;
    logic [3:0]   aluop;
    logic         addsub;

    // status
    logic         done;
    logic         busy;

    modport master (
        output run, din,
        input  rin, rout, ain, gin, gout, dinout, aluop, addsub, done, busy
    );

    modport slave (
        input  run, din,
        output rin, rout, ain, gin, gout, dinout, aluop, addsub, done, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-step (T0..T3) control FSM for a simple bus-based
// processor datapath.
// T0 waits for Run and captures the instruction word into IR. The later
// steps drive register, ALU and bus enables. The Moore outputs are decoded
// from (state, IR) one cycle early, using the values those registers will
// hold next. They are then registered, so each output flop reflects the
// current state and IR without any combinational path to the pins.
module alu_sequencer #(
    parameter int n = 16
) (
    input  logic           clock,
    input  logic           resetn,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_LAST_ALU = 4'b0101;
    localparam logic [3:0] OP_MV      = 4'b0110;
    localparam logic [3:0] OP_MVI     = 4'b0111;

    state_t       state_reg, state_next;
    logic [n-1:0] ir_reg, ir_next;

    logic [7:0]   rin_reg, rin_next;
    logic [7:0]   rout_reg, rout_next;
    logic         ain_reg, ain_next;
    logic         gin_reg, gin_next;
    logic         gout_reg, gout_next;
    logic         dinout_reg, dinout_next;
    logic [3:0]   aluop_reg, aluop_next;
    logic         addsub_reg, addsub_next;
    logic         done_reg, done_next;
    logic         busy_reg, busy_next;

    // Fields of the instruction currently held in IR (used for the T1 branch).
    logic [3:0]   op_cur;
    logic         op_cur_is_alu;

    assign op_cur        = ir_reg[15:12];
    assign op_cur_is_alu = (op_cur <= OP_LAST_ALU);

    // Fields of the instruction that IR will hold next cycle (used for output decode).
    logic [3:0]   op_next;
    logic [2:0]   x_next;
    logic [2:0]   y_next;
    logic         op_next_is_alu;
    logic [7:0]   x_sel_next;
    logic [7:0]   y_sel_next;

    assign op_next        = ir_next[15:12];
    assign x_next         = ir_next[11:9];
    assign y_next         = ir_next[8:6];
    assign op_next_is_alu = (op_next <= OP_LAST_ALU);

    // One-hot register selects for the X and Y fields.
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg_sel
        assign x_sel_next[gi] = (x_next == 3'(gi));
        assign y_sel_next[gi] = (y_next == 3'(gi));
    end

    // Step sequencing.
    // Run is looked at only in T0. mv, mvi and illegal opcodes finish in T1;
    // ALU opcodes continue through T2 and T3.
    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        case (state_reg)
            T0: begin
                if (bus.run) begin
                    state_next = T1;
                    ir_next    = bus.din;
                end
            end
            T1:      state_next = op_cur_is_alu ? T2 : T0;
            T2:      state_next = T3;
            T3:      state_next = T0;
            default: state_next = T0;
        endcase
    end

    // Decode the enables for the step that starts next cycle.
    // Any enable that a step does not name stays 0.
    always_comb begin
        rin_next    = '0;
        rout_next   = '0;
        ain_next    = 1'b0;
        gin_next    = 1'b0;
        gout_next   = 1'b0;
        dinout_next = 1'b0;
        aluop_next  = '0;
        addsub_next = 1'b0;
        done_next   = 1'b0;
        busy_next   = (state_next != T0);
        case (state_next)
            T0: begin
            end
            T1: begin
                if (op_next == OP_MV) begin
                    rout_next = y_sel_next;
                    rin_next  = x_sel_next;
                    done_next = 1'b1;
                end else if (op_next == OP_MVI) begin
                    dinout_next = 1'b1;
                    rin_next    = x_sel_next;
                    done_next   = 1'b1;
                end else if (op_next_is_alu) begin
                    rout_next = x_sel_next;
                    ain_next  = 1'b1;
                end else begin
                    // Illegal opcode: behaves as a nop and completes at once.
                    done_next = 1'b1;
                end
            end
            T2: begin
                rout_next   = y_sel_next;
                gin_next    = 1'b1;
                aluop_next  = op_next;
                addsub_next = (op_next == OP_SUB);
            end
            T3: begin
                gout_next = 1'b1;
                rin_next  = x_sel_next;
                done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // FSM state, IR and the registered Moore outputs.
    // Reset clears all of them at once, even with no clock running, so an
    // instruction that is cut off never gets its Done.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= T0;
            ir_reg     <= '0;
            rin_reg    <= '0;
            rout_reg   <= '0;
            ain_reg    <= 1'b0;
            gin_reg    <= 1'b0;
            gout_reg   <= 1'b0;
            dinout_reg <= 1'b0;
            aluop_reg  <= '0;
            addsub_reg <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ir_reg     <= ir_next;
            rin_reg    <= rin_next;
            rout_reg   <= rout_next;
            ain_reg    <= ain_next;
            gin_reg    <= gin_next;
            gout_reg   <= gout_next;
            dinout_reg <= dinout_next;
            aluop_reg  <= aluop_next;
            addsub_reg <= addsub_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign bus.rin    = rin_reg;
    assign bus.rout   = rout_reg;
    assign bus.ain    = ain_reg;
    assign bus.gin    = gin_reg;
    assign bus.gout   = gout_reg;
    assign bus.dinout = dinout_reg;
    assign bus.aluop  = aluop_reg;
    assign bus.addsub = addsub_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = busy_reg;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter n, default 16, data/instruction word width.
REQ-002 Clock  input  1  system clock, all state updates on rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Run  input  1  start request, sampled only in state T0.
REQ-005 DIN  input  n  instruction word in T0, immediate operand in T1 of mvi.
REQ-006 Rin  output  8  register write enables, bit i selects R[i].
REQ-007 Rout  output  8  register-to-bus drive enables, bit i selects R[i].
REQ-008 Ain  output  1  ALU operand-A register load.
REQ-009 Gin  output  1  ALU result register G load.
REQ-010 Gout  output  1  G-to-bus drive enable.
REQ-011 DINout  output  1  DIN-to-bus drive enable.
REQ-012 ALUop  output  4  ALU operation select.
REQ-013 Addsub  output  1  add/subtract hint to ALU, 1 = subtract.
REQ-014 Done  output  1  final cycle of current instruction.
REQ-015 Busy  output  1  high whenever state is not T0.

Function
REQ-016 Internal IR (n bits) SHALL load DIN on a rising edge in T0 with Run=1.
REQ-017 Decode fields: opcode=IR[15:12], X=IR[11:9], Y=IR[8:6]; IR[5:0] ignored.
REQ-018 Opcodes: 0000 add, 0001 sub, 0010 slt, 0011 sll, 0100 srl, 0101 and, 0110 mv, 0111 mvi, 1000-1111 illegal.
REQ-019 FSM states T0, T1, T2, T3; T0 -> T1 on Run=1, else hold T0.
REQ-020 All outputs SHALL be Moore, decoded from state and IR only; any enable not listed for a step is 0.
REQ-021 T0: all enables 0, Done=0, ALUop=0000, Addsub=0.
REQ-022 T1 mv: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
REQ-023 T1 mvi: DINout=1, Rin[X]=1, Done=1; next T0.
REQ-024 T1 ALU opcode (0000-0101): Rout[X]=1, Ain=1; next T2.
REQ-025 T2: Rout[Y]=1, Gin=1, ALUop=opcode, Addsub=1 only for sub; next T3.
REQ-026 T3: Gout=1, Rin[X]=1, Done=1; next T0.
REQ-027 T1 illegal opcode: no enables, Done=1 (nop); next T0.
REQ-028 Latency: mv/mvi/illegal 2 cycles from Run sample to Done; ALU ops 4 cycles.
REQ-029 Run in T1-T3 SHALL be ignored; Run held high in T0 after Done starts next instruction immediately (back-to-back, no idle cycle).
REQ-030 At most one of {any Rout bit, Gout, DINout} SHALL be 1 in any cycle; at most one Rin bit SHALL be 1.
REQ-031 X=Y is legal: mv R3,R3 asserts Rout[3] and Rin[3] together.

Reset
REQ-032 Resetn=0 SHALL immediately force state T0, IR=0, all outputs 0, independent of Clock.
REQ-033 Reset mid-instruction SHALL abort it with no Done; after release, FSM waits for Run in T0.

Verification
REQ-034 Resetn low, then high, Run=0 for 5 cycles -> state T0, all outputs 0, Busy=0.
REQ-035 Run=1, DIN=16'h0280 (add R1,R2) -> T1 Rout=8'h02 Ain=1; T2 Rout=8'h04 Gin=1 ALUop=0000 Addsub=0; T3 Gout=1 Rin=8'h02 Done=1.
REQ-036 Run=1, DIN=16'h7600 (mvi R3) then DIN=16'h00AB -> T1 DINout=1 Rin=8'h08 Done=1; next cycle T0.
REQ-037 Run held 1, DIN=16'h1940 (sub R4,R5) then 16'h6E00 (mv R7,R0) -> sub T2 ALUop=0001 Addsub=1, T3 Rin=8'h10 Done; next cycle T0 captures mv, T1 Rout=8'h01 Rin=8'h80 Done=1.
REQ-038 Run=1, DIN=16'hF000 (illegal) -> T1 Done=1, all enables 0, back to T0.
REQ-039 Resetn pulsed low during T2 of add -> outputs 0 asynchronously, no Done, T0 after release; bench checks one-hot rules of REQ-030 every cycle throughout.
